shift_engine: RTL and testbench

Parametrised multi-cycle shift unit for the ALU datapath, successor to the fixed 1-bit shifter. Selects operand A or B and direction from `ALU_FUN`, and shifts by a runtime amount (0..DATA_W-1) one bit per cycle under a small FSM. Supports logical, arithmetic and (optionally) rotate modes. Reports completion with a one-cycle `SHIFT_flag` pulse, a held result and the last bit shifted out.

---
 rtl/shift_engine_if.sv | 27 ++
 rtl/shift_engine.sv | 117 +++++++++++
 tb/tb_shift_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/shift_engine_if.sv
// Request/result bundle between the ALU sequencer and shift_engine.
// master drives the operation request, slave returns status and result.
interface shift_engine_if #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = $clog2(DATA_W)
);
    logic              start;
    logic [3:0]        ALU_FUN;
    logic [1:0]        shift_mode;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [AMT_W-1:0]  shamt;
    logic              busy;
    logic [DATA_W-1:0] SHIFT_out;
    logic              SHIFT_flag;
    logic              SHIFT_carry;

    modport master (
        output start, ALU_FUN, shift_mode, A, B, shamt,
        input  busy, SHIFT_out, SHIFT_flag, SHIFT_carry
    );

    modport slave (
        input  start, ALU_FUN, shift_mode, A, B, shamt,
        output busy, SHIFT_out, SHIFT_flag, SHIFT_carry
    );
endinterface

// File: rtl/shift_engine.sv
// Multi-cycle shifter: one bit per cycle, logical/arithmetic (rotate with SHIFT_ROTATE_EN).
// Latency shamt+1 cycles to the SHIFT_flag pulse; result and carry held until next completion.
// No queuing: start is sampled only in IDLE, so requests while busy are dropped.
module shift_engine #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic           clk,
    input  logic           RST,
    shift_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] work, work_nxt;
    logic [AMT_W-1:0]  count, count_nxt;
    logic              left, left_nxt;
    logic [1:0]        mode, mode_nxt;
    logic              carry, carry_nxt;
    logic [DATA_W-1:0] out_q, out_nxt;
    logic              cout_q, cout_nxt;
    logic              flag_q, flag_nxt;
    logic              busy_q;

    logic              rot;
    logic              arith;
    logic [DATA_W-1:0] stepped;
    logic              step_carry;

`ifdef SHIFT_ROTATE_EN
    assign rot = (mode == 2'b10);
`else
    assign rot = 1'b0;
`endif
    assign arith = (mode == 2'b01);

    // Single-bit step; arithmetic right re-fills from the MSB, which the step itself preserves.
    always_comb begin
        stepped    = work;
        step_carry = 1'b0;
        if (left) begin
            stepped    = {work[DATA_W-2:0], rot ? work[DATA_W-1] : 1'b0};
            step_carry = work[DATA_W-1];
        end else begin
            stepped    = {rot ? work[0] : (arith & work[DATA_W-1]), work[DATA_W-1:1]};
            step_carry = work[0];
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        count_nxt = count;
        left_nxt  = left;
        mode_nxt  = mode;
        carry_nxt = carry;
        out_nxt   = out_q;
        cout_nxt  = cout_q;
        flag_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.ALU_FUN[3:2] == 2'b11)) begin
                    work_nxt  = bus.ALU_FUN[1] ? bus.B : bus.A;
                    left_nxt  = bus.ALU_FUN[0];
                    mode_nxt  = bus.shift_mode;
                    count_nxt = bus.shamt;
                    carry_nxt = 1'b0;
                    state_nxt = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_nxt  = stepped;
                carry_nxt = step_carry;
                count_nxt = count - AMT_W'(1);
                if (count == AMT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_nxt   = work;
                cout_nxt  = carry;
                flag_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            left   <= 1'b0;
            mode   <= 2'b00;
            carry  <= 1'b0;
            out_q  <= '0;
            cout_q <= 1'b0;
            flag_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            count  <= count_nxt;
            left   <= left_nxt;
            mode   <= mode_nxt;
            carry  <= carry_nxt;
            out_q  <= out_nxt;
            cout_q <= cout_nxt;
            flag_q <= flag_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.SHIFT_out   = out_q;
    assign bus.SHIFT_flag  = flag_q;
    assign bus.SHIFT_carry = cout_q;
endmodule

// File: tb/tb_shift_engine.sv
// Randomised bench for shift_engine against an arithmetic reference model.
module tb_shift_engine;
    localparam int W = 16;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    shift_engine_if #(.DATA_W(W)) sh ();
    shift_engine #(.DATA_W(W)) u_dut (.clk(clk), .RST(RST), .bus(sh));

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_r, held_out;
    logic        exp_c, held_c;
    int          exp_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void model(input logic [3:0] fun, input logic [1:0] mode,
                                  input logic [15:0] a, input logic [15:0] b, input int n,
                                  output logic [15:0] r, output logic c);
        logic [15:0] op;
        bit rotate;
        op = fun[1] ? b : a;
`ifdef SHIFT_ROTATE_EN
        rotate = (mode == 2'b10);
`else
        rotate = 1'b0;
`endif
        if (n == 0) begin
            r = op;
            c = 1'b0;
        end else if (fun[0]) begin
            r = rotate ? ((op << n) | (op >> (W - n))) : (op << n);
            c = op[W - n];
        end else begin
            if (rotate)              r = (op >> n) | (op << (W - n));
            else if (mode == 2'b01)  r = $signed(op) >>> n;
            else                     r = op >> n;
            c = op[n - 1];
        end
    endfunction

    task automatic launch(input logic [3:0] fun, input logic [1:0] mode,
                          input logic [15:0] a, input logic [15:0] b, input int n);
        sh.ALU_FUN    = fun;
        sh.shift_mode = mode;
        sh.A          = a;
        sh.B          = b;
        sh.shamt      = 4'(n);
        sh.start      = 1'b1;
        model(fun, mode, a, b, n, exp_r, exp_c);
        exp_n = n;
    endtask

    // Called at the negedge where start is presented; returns at the flag-cycle negedge.
    task automatic wait_done(input bit poke);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        @(negedge clk);
        while (cyc < 40 && !seen) begin
            sh.start = 1'b0;
            if (sh.SHIFT_flag) seen = 1;
            else begin
                chk("busy", sh.busy, 1);
                chk("held_out", sh.SHIFT_out, held_out);
                chk("held_carry", sh.SHIFT_carry, held_c);
                if (poke && cyc == 1) begin
                    sh.start   = 1'b1;
                    sh.ALU_FUN = 4'b1100 | 4'($urandom_range(0, 3));
                    sh.A       = 16'($urandom);
                    sh.B       = 16'($urandom);
                    sh.shamt   = 4'd0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk("flag_seen", seen, 1);
        chk("latency", cyc, exp_n + 1);
        chk("busy_in_flag", sh.busy, 0);
        chk("out", sh.SHIFT_out, exp_r);
        chk("carry", sh.SHIFT_carry, exp_c);
        held_out = exp_r;
        held_c   = exp_c;
    endtask

    task automatic idle_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            sh.start = 1'b0;
            chk("idle_flag", sh.SHIFT_flag, 0);
            chk("idle_busy", sh.busy, 0);
            chk("idle_out", sh.SHIFT_out, held_out);
        end
    endtask

    initial begin
        RST = 1'b1;
        sh.start = 1'b0; sh.ALU_FUN = 4'h0; sh.shift_mode = 2'b00;
        sh.A = 16'h0; sh.B = 16'h0; sh.shamt = 4'd0;
        held_out = 16'h0; held_c = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        chk("rst_busy", sh.busy, 0);
        chk("rst_out", sh.SHIFT_out, 0);
        chk("rst_flag", sh.SHIFT_flag, 0);
        chk("rst_carry", sh.SHIFT_carry, 0);

        launch(4'b1101, 2'b00, 16'h8001, 16'h0, 4);    wait_done(0);
        chk("tp1_out", sh.SHIFT_out, 16'h0010);
        idle_check(1);
        launch(4'b1100, 2'b01, 16'h8004, 16'h0, 3);    wait_done(0);
        chk("tp2_out", sh.SHIFT_out, 16'hF000);
        chk("tp2_carry", sh.SHIFT_carry, 1);
        idle_check(1);
        launch(4'b1111, 2'b00, 16'h0, 16'h1234, 0);    wait_done(0);
        chk("tp3_out", sh.SHIFT_out, 16'h1234);
        idle_check(1);
        launch(4'b1110, 2'b10, 16'h0, 16'h8001, 1);    wait_done(0);
`ifdef SHIFT_ROTATE_EN
        chk("tp4_out", sh.SHIFT_out, 16'hC000);
`else
        chk("tp4_out", sh.SHIFT_out, 16'h4000);
`endif
        chk("tp4_carry", sh.SHIFT_carry, 1);

        // back-to-back: second start presented in the flag cycle of the first
        launch(4'b1101, 2'b00, 16'h00F0, 16'h0, 3);    wait_done(0);
        launch(4'b1101, 2'b00, 16'h0001, 16'h0, 1);    wait_done(0);
        chk("b2b_out", sh.SHIFT_out, 16'h0002);
        idle_check(2);

        // start while busy is dropped
        launch(4'b1100, 2'b00, 16'hA5A5, 16'h0, 5);    wait_done(1);
        idle_check(3);

        // invalid function code
        @(negedge clk);
        sh.ALU_FUN = 4'b0101; sh.shamt = 4'd2; sh.start = 1'b1;
        idle_check(4);

        // reset mid-operation
        launch(4'b1101, 2'b00, 16'hFFFF, 16'h0, 8);
        repeat (3) begin @(negedge clk); sh.start = 1'b0; end
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        held_out = 16'h0; held_c = 1'b0;
        chk("abort_busy", sh.busy, 0);
        chk("abort_out", sh.SHIFT_out, 0);
        chk("abort_carry", sh.SHIFT_carry, 0);
        idle_check(12);

        for (int i = 0; i < 80; i++) begin
            launch(4'b1100 | 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
            wait_done(exp_n >= 1 && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
        end
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
